// File: rtl/rep_ecx_ctrl.sv
// rep_ecx_ctrl: iteration sequencer for REP/REPE/REPNE string operations.
// Keeps a shadow ECX that feeds alu3, launches one string-op iteration at a
// time, writes the alu3-decremented ECX back to the register file and ends the
// sequence on ECX reaching zero or on the ZF condition of the prefix.
module rep_ecx_ctrl #(
   parameter int             ECX_W      = 32,
   parameter logic [4:0]     OP_ECX_DEC = 5'b11000,
   parameter int             CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       rep_type,
   input  logic [ECX_W-1:0] ecx_in,
   output logic [ECX_W-1:0] ecx_out,
   output logic [4:0]       alu3_op_out,
   input  logic [ECX_W-1:0] alu3_ecx_res,
   output logic             iter_go,
   input  logic             iter_done,
   input  logic             zf_in,
   input  logic             flush,
   output logic             ecx_wr_en,
   output logic [ECX_W-1:0] ecx_wr_data,
   output logic             stall_fe,
   output logic             rep_done,
   output logic [CNT_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ISSUE,
      S_WAIT,
      S_DEC,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      REP_NONE  = 2'b00,
      REP_PLAIN = 2'b01,
      REP_E     = 2'b10,
      REP_NE    = 2'b11
   } rep_t;

   state_t           state;
   logic [ECX_W-1:0] ecx_q;
   logic             zf_q;
   rep_t             type_q;
   logic [CNT_W-1:0] cnt_q;

   // Sequencer state, shadow ECX, latched ZF/prefix type and iteration counter.
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      if (!rst_n) begin
         state  <= S_IDLE;
         ecx_q  <= '0;
         zf_q   <= 1'b0;
         type_q <= REP_NONE;
         cnt_q  <= '0;
      end else if (flush && state != S_IDLE) begin
         // Abort: the in-flight iteration and any pending write are dropped.
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  ecx_q  <= ecx_in;
                  type_q <= rep_t'(rep_type);
                  cnt_q  <= '0;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (type_q != REP_NONE && ecx_q == '0) state <= S_DONE;
               else                                     state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (iter_done) begin
                  zf_q  <= zf_in;
                  state <= (type_q == REP_NONE) ? S_DONE : S_DEC;
               end
            end
            S_DEC: begin
               ecx_q <= alu3_ecx_res;
               if (alu3_ecx_res == '0)           state <= S_DONE;
               else if (type_q == REP_E  && !zf_q) state <= S_DONE;
               else if (type_q == REP_NE &&  zf_q) state <= S_DONE;
               else                               state <= S_ISSUE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output decodes of the state register.
   // NOTE: the pulses are masked by flush so the abort cycle has no side effects
   // downstream, even though the state register still shows the old state.
   assign start_ready = (state == S_IDLE);
   assign stall_fe    = (state != S_IDLE);
   assign iter_go     = (state == S_ISSUE) && !flush;
   assign alu3_op_out = (state == S_DEC) ? OP_ECX_DEC : 5'b0;
   assign ecx_wr_en   = (state == S_DEC) && !flush;
   assign ecx_wr_data = alu3_ecx_res;
   assign rep_done    = (state == S_DONE) && !flush;
   assign ecx_out     = ecx_q;
   assign iter_cnt    = cnt_q;

endmodule

// File: tb/tb_rep_ecx_ctrl.sv
// Self-checking bench for rep_ecx_ctrl: directed REP-prefix scenarios plus
// randomized sequences compared against a sequence-level reference model.
module tb_rep_ecx_ctrl;

   localparam logic [4:0] OP = 5'b11000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [1:0]  rep_type;
   logic [31:0] ecx_in;
   logic [31:0] ecx_out;
   logic [4:0]  alu3_op_out;
   logic [31:0] alu3_ecx_res;
   logic        iter_go;
   logic        iter_done;
   logic        zf_in;
   logic        flush;
   logic        ecx_wr_en;
   logic [31:0] ecx_wr_data;
   logic        stall_fe;
   logic        rep_done;
   logic [15:0] iter_cnt;

   int checks = 0;
   int errors = 0;

   // Observations from one sequence run
   int          obs_gos, obs_first_go, obs_done_cyc;
   int          obs_bad_gap, obs_bad_stall, obs_bad_op;
   bit          obs_timeout, obs_idle_ok;
   logic [15:0] obs_cnt;
   logic [31:0] obs_ecx;
   logic [31:0] obs_wr[$];
   logic [31:0] exp_wr[$];

   always #5 clk = ~clk;

   // alu3 ECX-decrement path
   assign alu3_ecx_res = ecx_out - 32'd1;

   rep_ecx_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .rep_type     (rep_type),
      .ecx_in       (ecx_in),
      .ecx_out      (ecx_out),
      .alu3_op_out  (alu3_op_out),
      .alu3_ecx_res (alu3_ecx_res),
      .iter_go      (iter_go),
      .iter_done    (iter_done),
      .zf_in        (zf_in),
      .flush        (flush),
      .ecx_wr_en    (ecx_wr_en),
      .ecx_wr_data  (ecx_wr_data),
      .stall_fe     (stall_fe),
      .rep_done     (rep_done),
      .iter_cnt     (iter_cnt)
   );

   // Reference model: REP semantics over the whole sequence.
   function automatic void model(input logic [1:0] t, input logic [31:0] e,
                                 input logic [63:0] zb, output int iters,
                                 output logic [31:0] ecx_f);
      exp_wr.delete();
      iters = 0;
      ecx_f = e;
      if (t == 2'b00) begin
         iters = 1;
      end else if (e != 0) begin
         for (int i = 0; i < 64; i++) begin
            iters++;
            ecx_f = ecx_f - 1;
            exp_wr.push_back(ecx_f);
            if (ecx_f == 0) break;
            if (t == 2'b10 && !zb[i]) break;
            if (t == 2'b11 &&  zb[i]) break;
         end
      end
   endfunction

   // Drive one sequence: accept in cycle 0, answer each iter_go with iter_done
   // dly cycles later, record everything until rep_done or the cycle budget.
   task automatic run_seq(input logic [1:0] t, input logic [31:0] e,
                          input logic [63:0] zb, input int dly);
      int cyc, done_at, zi, last_done;
      obs_gos = 0; obs_first_go = -1; obs_done_cyc = -1;
      obs_bad_gap = 0; obs_bad_stall = 0; obs_bad_op = 0;
      obs_timeout = 1'b1; obs_idle_ok = 1'b0;
      obs_wr.delete();
      @(negedge clk);
      start_valid = 1'b1; rep_type = t; ecx_in = e; iter_done = 1'b0; flush = 1'b0;
      cyc = 0; done_at = -1; zi = 0; last_done = -1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         cyc++;
         if (!stall_fe) obs_bad_stall++;
         if (alu3_op_out !== (ecx_wr_en ? OP : 5'b0)) obs_bad_op++;
         if (iter_go) begin
            obs_gos++;
            if (obs_first_go < 0) obs_first_go = cyc;
            else if (cyc != last_done + 2) obs_bad_gap++;
            done_at = cyc + dly;
         end
         if (ecx_wr_en) obs_wr.push_back(ecx_wr_data);
         if (rep_done) begin
            obs_done_cyc = cyc; obs_timeout = 1'b0;
            obs_cnt = iter_cnt; obs_ecx = ecx_out;
            start_valid = 1'b0; iter_done = 1'b0;
            break;
         end
         // busy-time start requests with junk operands must be ignored
         start_valid = 1'($urandom_range(0, 1));
         ecx_in      = $urandom;
         rep_type    = 2'($urandom);
         iter_done   = (cyc == done_at);
         if (iter_done) begin
            zf_in = zb[zi[5:0]];
            zi++;
            last_done = cyc;
         end else begin
            zf_in = 1'($urandom);
         end
      end
      start_valid = 1'b0; iter_done = 1'b0;
      @(negedge clk);
      obs_idle_ok = !stall_fe && start_ready && !rep_done && !iter_go && !ecx_wr_en;
   endtask

   task automatic check_seq(input string name, input logic [1:0] t, input logic [31:0] e,
                            input logic [63:0] zb, input int dly);
      int          exp_iters;
      logic [31:0] exp_ecx;
      model(t, e, zb, exp_iters, exp_ecx);
      run_seq(t, e, zb, dly);
      checks++;
      if (obs_timeout !== 1'b0) begin
         errors++; $display("FAIL %s timeout: no rep_done within budget", name);
         return;
      end
      checks++;
      if (obs_gos !== exp_iters) begin
         errors++; $display("FAIL %s iter_go count got %0d want %0d", name, obs_gos, exp_iters);
      end
      checks++;
      if (obs_cnt !== 16'(exp_iters)) begin
         errors++; $display("FAIL %s iter_cnt got %0d want %0d", name, obs_cnt, exp_iters);
      end
      checks++;
      if (obs_wr.size() !== exp_wr.size()) begin
         errors++; $display("FAIL %s write count got %0d want %0d", name, obs_wr.size(), exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
         checks++;
         if (obs_wr[i] !== exp_wr[i]) begin
            errors++; $display("FAIL %s write[%0d] got %h want %h", name, i, obs_wr[i], exp_wr[i]);
         end
      end
      checks++;
      if (obs_ecx !== exp_ecx) begin
         errors++; $display("FAIL %s ecx_out got %h want %h", name, obs_ecx, exp_ecx);
      end
      checks++;
      if (exp_iters == 0 && obs_done_cyc !== 2) begin
         errors++; $display("FAIL %s zero-iter rep_done cycle got %0d want 2", name, obs_done_cyc);
      end else if (exp_iters > 0 && obs_first_go !== 2) begin
         errors++; $display("FAIL %s first iter_go cycle got %0d want 2", name, obs_first_go);
      end
      checks++;
      if (obs_bad_gap != 0 || obs_bad_stall != 0 || obs_bad_op != 0) begin
         errors++; $display("FAIL %s timing got gap=%0d stall=%0d op=%0d want all 0",
                            name, obs_bad_gap, obs_bad_stall, obs_bad_op);
      end
      checks++;
      if (!obs_idle_ok) begin
         errors++; $display("FAIL %s post-done idle got stall_fe=%b start_ready=%b want 0/1",
                            name, stall_fe, start_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_valid = 1'b0; rep_type = 2'b00; ecx_in = '0;
      iter_done = 1'b0; zf_in = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({iter_go, ecx_wr_en, rep_done, stall_fe, start_ready} !== 5'b00001 ||
          ecx_out !== 32'd0 || iter_cnt !== 16'd0 || alu3_op_out !== 5'd0) begin
         errors++;
         $display("FAIL reset got go=%b wr=%b done=%b stall=%b rdy=%b ecx=%h cnt=%0d op=%h want 0,0,0,0,1,0,0,0",
                  iter_go, ecx_wr_en, rep_done, stall_fe, start_ready, ecx_out, iter_cnt, alu3_op_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      check_seq("rep3",      2'b01, 32'd3, 64'd0, 2);
      check_seq("rep0",      2'b01, 32'd0, 64'd0, 2);
      check_seq("repe5",     2'b10, 32'd5, 64'b01, 2);
      check_seq("repne4",    2'b11, 32'd4, 64'b100, 2);
      check_seq("none",      2'b00, 32'd7, 64'd0, 1);
      check_seq("repe0",     2'b10, 32'd0, 64'd0, 1);
      check_seq("wrap",      2'b11, 32'hFFFF_FFFF, 64'b100, 1);
      check_seq("rep1_fast", 2'b01, 32'd1, 64'd0, 1);
   endtask

   // Starts a REP ecx=3 sequence and stops with the controller in WAIT.
   task automatic start_to_wait();
      @(negedge clk); start_valid = 1'b1; rep_type = 2'b01; ecx_in = 32'd3;
      @(negedge clk); start_valid = 1'b0;                    // CHECK
      @(negedge clk);                                        // ISSUE
      checks++;
      if (iter_go !== 1'b1) begin
         errors++; $display("FAIL issue_latency iter_go got %b want 1", iter_go);
      end
      @(negedge clk);                                        // WAIT
   endtask

   task automatic test_flush_wait();
      int bad;
      start_to_wait();
      flush = 1'b1; iter_done = 1'b1; zf_in = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (stall_fe !== 1'b0 || start_ready !== 1'b1) begin
         errors++; $display("FAIL flush_wait idle got stall_fe=%b start_ready=%b want 0/1", stall_fe, start_ready);
      end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (iter_go || ecx_wr_en || rep_done) bad++;
      end
      iter_done = 1'b0;
      checks++;
      if (bad != 0 || ecx_out !== 32'd3 || iter_cnt !== 16'd1) begin
         errors++; $display("FAIL flush_wait after got bad=%0d ecx=%h cnt=%0d want 0,3,1", bad, ecx_out, iter_cnt);
      end
   endtask

   task automatic test_flush_dec();
      start_to_wait();
      iter_done = 1'b1; zf_in = 1'b0;
      @(negedge clk);                                        // DEC
      iter_done = 1'b0; flush = 1'b1;
      #1;
      checks++;
      if (ecx_wr_en !== 1'b0) begin
         errors++; $display("FAIL flush_dec write got %b want 0", ecx_wr_en);
      end
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (start_ready !== 1'b1 || rep_done !== 1'b0 || ecx_wr_en !== 1'b0) begin
         errors++; $display("FAIL flush_dec idle got rdy=%b done=%b wr=%b want 1,0,0", start_ready, rep_done, ecx_wr_en);
      end
   endtask

   task automatic test_reset_dec();
      start_to_wait();
      iter_done = 1'b1; zf_in = 1'b0;
      @(negedge clk);                                        // DEC
      iter_done = 1'b0;
      checks++;
      if (ecx_wr_en !== 1'b1 || ecx_wr_data !== 32'd2 || alu3_op_out !== OP) begin
         errors++; $display("FAIL reset_dec pre got wr=%b data=%h op=%h want 1,2,18", ecx_wr_en, ecx_wr_data, alu3_op_out);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({iter_go, ecx_wr_en, rep_done, stall_fe, start_ready} !== 5'b00001 ||
          ecx_out !== 32'd0 || iter_cnt !== 16'd0 || alu3_op_out !== 5'd0) begin
         errors++; $display("FAIL reset_dec got go=%b wr=%b done=%b stall=%b rdy=%b ecx=%h cnt=%0d want 0,0,0,0,1,0,0",
                            iter_go, ecx_wr_en, rep_done, stall_fe, start_ready, ecx_out, iter_cnt);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         check_seq("random", 2'($urandom), 32'($urandom_range(0, 10)),
                   {$urandom, $urandom}, $urandom_range(1, 3));
      end
   endtask

   task automatic test_back_to_back();
      check_seq("b2b_a", 2'b01, 32'd2, 64'd0, 1);
      check_seq("b2b_b", 2'b10, 32'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_flush_wait();
      test_flush_dec();
      test_reset_dec();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
